pll_lock_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 16 +
 rtl/sync2.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 128 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset/lock sequencer.
//   pll_seq_state_t : 3-bit sequencer state, values visible on state_dbg
//   PLL_SEQ_RETRY_W : width of the failed-attempt counter
package pll_seq_pkg;

  localparam int unsigned PLL_SEQ_RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_seq_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop bit synchronizer, async active-low reset to 0.
//   clk   : destination clock
//   rst_n : async active-low reset
//   d     : asynchronous input bit
//   q     : synchronized output (two destination edges of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse, lock wait with timeout/retries, lock qualification and
// loss-of-lock restart, all in the refclk domain.
//   refclk     : reference clock (sole clock)
//   rst_n      : async active-low reset
//   pll_locked : PLL lock indication, asynchronous
//   restart    : single-cycle request to rerun the whole sequence
//   pll_rst    : PLL reset, active-high (RESET_PLL and FAIL)
//   ready      : high only in RUN
//   lock_lost  : one-cycle pulse when lock drops in RUN
//   fail       : high in FAIL
//   retry_cnt  : failed lock attempts in the current sequence
//   state_dbg  : registered state encoding
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                       refclk,
  input  logic                       rst_n,
  input  logic                       pll_locked,
  input  logic                       restart,
  output logic                       pll_rst,
  output logic                       ready,
  output logic                       lock_lost,
  output logic                       fail,
  output logic [PLL_SEQ_RETRY_W-1:0] retry_cnt,
  output logic [2:0]                 state_dbg
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  pll_seq_state_t             state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PLL_SEQ_RETRY_W-1:0] retry_d, retry_inc;
  logic                       lost_d;
  logic                       locked_s;

  // Lock input into the refclk domain
  sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State, counter and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
      ready     <= (state_d == ST_RUN);
      lock_lost <= lost_d;
      fail      <= (state_d == ST_FAIL);
      retry_cnt <= retry_d;
    end
  end

  assign state_dbg = state_q;
  assign retry_inc = retry_cnt + 1'b1;

  // Next-state, counter and retry logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_cnt;
    lost_d  = 1'b0;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_inc;
          state_d = (retry_inc == PLL_SEQ_RETRY_W'(MAX_RETRIES)) ? ST_FAIL : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        // Any dropout sends us back to wait; the timeout restarts, no retry
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_RESET_PLL;
          lost_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    // restart overrides everything, including a coincident lock loss
    if (restart) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    if (restart || (state_d != state_q)) cnt_d = '0;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with
// literal latencies plus a randomized run, all outputs compared every cycle
// against a phase/timestamp model of the sequencer.
module tb_pll_lock_sequencer;

  localparam int unsigned RST_C = 4;
  localparam int unsigned TO_C  = 20;
  localparam int unsigned ST_C  = 8;
  localparam int unsigned MR    = 2;

  // Phase numbering follows the documented state_dbg encoding
  localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst, ready, lock_lost, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int lost_pulses = 0;
  int rst_hi_samples = 0;

  always #5 refclk = ~refclk;

  pll_lock_sequencer #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TO_C),
    .STABLE_CYCLES (ST_C),
    .MAX_RETRIES   (MR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: current phase, the cycle it was entered, a 2-deep lock history
  int m_phase = P_RESET;
  int m_cyc   = 0;
  int m_since = 0;
  int m_retry = 0;
  bit m_lost  = 1'b0;
  bit m_hist[$] = '{1'b0, 1'b0};

  task automatic model_enter(input int p);
    m_phase = p;
    m_since = m_cyc;
  endtask

  task automatic model_step();
    bit ls;
    int dur;
    ls = m_hist.pop_front();
    m_hist.push_back(pll_locked);
    m_cyc++;
    dur = m_cyc - m_since;
    m_lost = 1'b0;
    if (restart) begin
      m_retry = 0;
      model_enter(P_RESET);
    end else if (m_phase == P_RESET) begin
      if (dur == RST_C) model_enter(P_WAIT);
    end else if (m_phase == P_WAIT) begin
      if (ls) model_enter(P_STABLE);
      else if (dur == TO_C) begin
        m_retry++;
        model_enter((m_retry == MR) ? P_FAIL : P_RESET);
      end
    end else if (m_phase == P_STABLE) begin
      if (!ls) model_enter(P_WAIT);
      else if (dur == ST_C) begin
        m_retry = 0;
        model_enter(P_RUN);
      end
    end else if (m_phase == P_RUN) begin
      if (!ls) begin
        m_lost = 1'b1;
        model_enter(P_RESET);
      end
    end
  endtask

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_RESET;
      m_cyc   = 0;
      m_since = 0;
      m_retry = 0;
      m_lost  = 1'b0;
      m_hist  = '{1'b0, 1'b0};
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model
  always @(negedge refclk) begin
    check("pll_rst",   int'(pll_rst),   int'(m_phase == P_RESET || m_phase == P_FAIL));
    check("ready",     int'(ready),     int'(m_phase == P_RUN));
    check("fail",      int'(fail),      int'(m_phase == P_FAIL));
    check("lock_lost", int'(lock_lost), int'(m_lost));
    check("retry_cnt", int'(retry_cnt), m_retry);
    check("state_dbg", int'(state_dbg), m_phase);
    if (lock_lost) lost_pulses++;
    if (pll_rst) rst_hi_samples++;
  end

  function automatic bit sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return ready;
      2:       return lock_lost;
      3:       return fail;
      default: return 1'b0;
    endcase
  endfunction

  // Negedges waited until the signal equals val (bounded)
  task automatic wait_until(input int which, input bit val, output int n);
    n = 0;
    do begin
      @(negedge refclk);
      n++;
    end while (sig(which) != val && n < 200);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lost0, rst0;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_state", int'(state_dbg), 0);
    check("reset_pll_rst", int'(pll_rst), 1);

    // Clean lock
    rst_n = 1'b1;
    wait_until(0, 1'b0, n);
    check("pll_rst_width", n, 4);
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    wait_until(1, 1'b1, n);
    check("ready_latency", n, 11);
    check("retry_after_lock", int'(retry_cnt), 0);

    // Loss of lock in RUN
    lost0 = lost_pulses;
    pll_locked = 1'b0;
    wait_until(2, 1'b1, n);
    check("lock_lost_latency", n, 3);
    check("ready_on_loss", int'(ready), 0);
    check("pll_rst_on_loss", int'(pll_rst), 1);
    pll_locked = 1'b1;
    wait_until(0, 1'b0, n);
    check("relock_rst_width", n, 4);

    // Glitch mid-STABLE: back to wait, no retry, no PLL reset
    repeat (3) @(negedge refclk);
    check("in_stable", int'(state_dbg), 2);
    rst0 = rst_hi_samples;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    wait_until(1, 1'b1, n);
    check("glitch_ready_latency", n, 11);
    check("glitch_no_pll_rst", rst_hi_samples - rst0, 0);
    check("glitch_no_retry", int'(retry_cnt), 0);
    check("single_lock_lost", lost_pulses - lost0, 1);

    // restart in RUN
    pulse_restart();
    check("restart_run_state", int'(state_dbg), 0);
    check("restart_run_pll_rst", int'(pll_rst), 1);
    wait_until(1, 1'b1, n);
    check("restart_run_relock", n, 13);

    // restart coincident with lock loss
    lost0 = lost_pulses;
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    check("coinc_no_lock_lost", int'(lock_lost), 0);
    check("coinc_state", int'(state_dbg), 0);
    repeat (3) @(negedge refclk);
    check("coinc_no_pulse", lost_pulses - lost0, 0);

    // Timeout and fail (pll_locked held low)
    pulse_restart();
    n = 0;
    do begin
      @(negedge refclk);
      n++;
      if (n == 30) check("retry_step1", int'(retry_cnt), 1);
    end while (!fail && n < 200);
    check("fail_latency", n, 48);
    check("fail_retry", int'(retry_cnt), 2);
    check("fail_pll_rst", int'(pll_rst), 1);
    repeat (50) @(negedge refclk);
    check("fail_sticky", int'(state_dbg), 4);

    // restart out of FAIL
    pll_locked = 1'b1;
    pulse_restart();
    check("restart_fail_clear", int'(fail), 0);
    check("restart_fail_retry", int'(retry_cnt), 0);
    wait_until(0, 1'b0, n);
    check("restart_fail_rst_width", n, 4);
    repeat (3) @(negedge refclk);
    check("stable_again", int'(state_dbg), 2);

    // Async reset between edges, mid-STABLE
    @(posedge refclk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pll_rst", int'(pll_rst), 1);
    check("async_ready", int'(ready), 0);
    check("async_state", int'(state_dbg), 0);
    check("async_retry", int'(retry_cnt), 0);
    @(negedge refclk);
    rst_n = 1'b1;
    wait_until(0, 1'b0, n);
    check("rerun_rst_width", n, 4);
    wait_until(1, 1'b1, n);
    check("rerun_ready", n, 9);

    // Randomized lock activity and restarts
    for (int i = 0; i < 3000; i++) begin
      @(negedge refclk);
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      restart = ($urandom_range(0, 149) == 0);
    end
    @(negedge refclk);
    restart = 1'b0;
    repeat (5) @(negedge refclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
